// File: rtl/ptw_arbiter.sv
// ptw_arbiter: shares one page-table walk unit (TWU) between the ITLB and the DTLB.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   i_req/i_va, d_req/d_va          level-held walk requests and miss addresses from each TLB
//   i_ack/i_pte/i_fault             one-cycle completion pulse and result for the ITLB
//   d_ack/d_pte/d_fault             one-cycle completion pulse and result for the DTLB
//   walk_req/walk_va                request to the TWU, held until walk_done
//   walk_done/walk_pte/walk_fault   TWU completion and result
//   flush                           sfence.vma pulse: discard any walk in flight
//   busy                            high whenever a walk is granted or being answered
//
// Every output is a flop; grants alternate when both TLBs request together.
module ptw_arbiter #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned PTE_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_va,
    output logic                  i_ack,
    output logic [PTE_WIDTH-1:0]  i_pte,
    output logic                  i_fault,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_va,
    output logic                  d_ack,
    output logic [PTE_WIDTH-1:0]  d_pte,
    output logic                  d_fault,
    output logic                  walk_req,
    output logic [ADDR_WIDTH-1:0] walk_va,
    input  logic                  walk_done,
    input  logic [PTE_WIDTH-1:0]  walk_pte,
    input  logic                  walk_fault,
    input  logic                  flush,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    // owner/last encoding: 0 = ITLB, 1 = DTLB
    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_q, last_d;
    logic                    drop_q, drop_d;
    logic                    walk_req_q, walk_req_d;
    logic [ADDR_WIDTH-1:0]   walk_va_q, walk_va_d;
    logic [PTE_WIDTH-1:0]    i_pte_q, i_pte_d;
    logic [PTE_WIDTH-1:0]    d_pte_q, d_pte_d;
    logic                    i_fault_q, i_fault_d;
    logic                    d_fault_q, d_fault_d;
    logic                    i_ack_q, i_ack_d;
    logic                    d_ack_q, d_ack_d;
    logic                    busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        drop_d     = drop_q;
        walk_req_d = walk_req_q;
        walk_va_d  = walk_va_q;
        i_pte_d    = i_pte_q;
        d_pte_d    = d_pte_q;
        i_fault_d  = i_fault_q;
        d_fault_d  = d_fault_q;

        unique case (state_q)
            StIdle: begin
                if (!flush && (i_req || d_req)) begin
                    // On a tie the DTLB wins only if the ITLB was served last.
                    owner_d    = d_req && (!i_req || !last_q);
                    walk_va_d  = owner_d ? d_va : i_va;
                    walk_req_d = 1'b1;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (walk_done) begin
                    walk_req_d = 1'b0;
                    drop_d     = 1'b0;
                    if (drop_q || flush) begin
                        state_d = StIdle;
                    end else begin
                        if (owner_q) begin
                            d_pte_d   = walk_pte;
                            d_fault_d = walk_fault;
                        end else begin
                            i_pte_d   = walk_pte;
                            i_fault_d = walk_fault;
                        end
                        state_d = StResp;
                    end
                end else if (flush) begin
                    // TWU transactions are never cut; remember to discard the result.
                    drop_d = 1'b1;
                end
            end
            StResp: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Registered outputs are computed from next state so they line up with it.
        i_ack_d = (state_d == StResp) && !owner_d;
        d_ack_d = (state_d == StResp) && owner_d;
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            drop_q     <= 1'b0;
            walk_req_q <= 1'b0;
            walk_va_q  <= '0;
            i_pte_q    <= '0;
            d_pte_q    <= '0;
            i_fault_q  <= 1'b0;
            d_fault_q  <= 1'b0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            drop_q     <= drop_d;
            walk_req_q <= walk_req_d;
            walk_va_q  <= walk_va_d;
            i_pte_q    <= i_pte_d;
            d_pte_q    <= d_pte_d;
            i_fault_q  <= i_fault_d;
            d_fault_q  <= d_fault_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign i_ack    = i_ack_q;
    assign i_pte    = i_pte_q;
    assign i_fault  = i_fault_q;
    assign d_ack    = d_ack_q;
    assign d_pte    = d_pte_q;
    assign d_fault  = d_fault_q;
    assign walk_req = walk_req_q;
    assign walk_va  = walk_va_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Self-checking bench for ptw_arbiter: directed scenarios plus a randomized
// round-robin run checked against a transaction-level model.
module tb_ptw_arbiter;

    localparam int AW = 64;
    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_req, d_req, walk_done, walk_fault, flush;
    logic [AW-1:0] i_va, d_va;
    logic [PW-1:0] walk_pte;
    logic          i_ack, i_fault, d_ack, d_fault, walk_req, busy;
    logic [PW-1:0] i_pte, d_pte;
    logic [AW-1:0] walk_va;

    int total = 0;
    int bad   = 0;

    // Model state: who was acked last (1 = DTLB) and the results each TLB should hold.
    bit            last_m;
    logic [PW-1:0] exp_i_pte, exp_d_pte;
    bit            exp_i_fault, exp_d_fault;

    ptw_arbiter #(.ADDR_WIDTH(AW), .PTE_WIDTH(PW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_req      (i_req),
        .i_va       (i_va),
        .i_ack      (i_ack),
        .i_pte      (i_pte),
        .i_fault    (i_fault),
        .d_req      (d_req),
        .d_va       (d_va),
        .d_ack      (d_ack),
        .d_pte      (d_pte),
        .d_fault    (d_fault),
        .walk_req   (walk_req),
        .walk_va    (walk_va),
        .walk_done  (walk_done),
        .walk_pte   (walk_pte),
        .walk_fault (walk_fault),
        .flush      (flush),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for walk_req; no checking here, caller compares ok.
    task automatic wait_walk_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (walk_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // TWU behaviour: answer lat cycles after walk_req is seen.
    task automatic twu_respond(input int lat, input logic [PW-1:0] pte, input bit fault);
        repeat (lat - 1) step();
        walk_done  = 1'b1;
        walk_pte   = pte;
        walk_fault = fault;
        step();
        walk_done  = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        i_req = 1'b0; d_req = 1'b0; walk_done = 1'b0; walk_fault = 1'b0; flush = 1'b0;
        i_va = '0; d_va = '0; walk_pte = '0;
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        step();
        last_m = 1'b1;
        exp_i_pte = '0; exp_d_pte = '0; exp_i_fault = 1'b0; exp_d_fault = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({walk_req, i_ack, d_ack, i_fault, d_fault, busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {walk_req, i_ack, d_ack, i_fault, d_fault, busy});
        end
        total++;
        if (walk_va !== '0) begin
            bad++; $display("FAIL reset_walk_va: got %h want 0", walk_va);
        end
        total++;
        if ({i_pte, d_pte} !== '0) begin
            bad++; $display("FAIL reset_pte: got %h %h want 0 0", i_pte, d_pte);
        end
    endtask

    task automatic test_single_i();
        i_va  = 64'h0000_0040_1234_5000;
        i_req = 1'b1;
        step();
        total++;
        if (walk_req !== 1'b1 || walk_va !== 64'h0000_0040_1234_5000) begin
            bad++; $display("FAIL single_grant: got req=%b va=%h want 1 %h",
                            walk_req, walk_va, 64'h0000_0040_1234_5000);
        end
        twu_respond(5, 64'h2000_0C01, 1'b0);
        total++;
        if (i_ack !== 1'b1 || d_ack !== 1'b0) begin
            bad++; $display("FAIL single_ack: got i=%b d=%b want 1 0", i_ack, d_ack);
        end
        total++;
        if (i_pte !== 64'h2000_0C01 || i_fault !== 1'b0) begin
            bad++; $display("FAIL single_pte: got %h/%b want 20000c01/0", i_pte, i_fault);
        end
        exp_i_pte = 64'h2000_0C01; exp_i_fault = 1'b0; last_m = 1'b0;
        i_req = 1'b0;
        step();
        total++;
        if (i_ack !== 1'b0 || busy !== 1'b0 || i_pte !== exp_i_pte) begin
            bad++; $display("FAIL single_after: got ack=%b busy=%b pte=%h want 0 0 %h",
                            i_ack, busy, i_pte, exp_i_pte);
        end
    endtask

    // Two ties from reset: expected grant order I, D, I, D.
    task automatic test_tie();
        bit            ok;
        bit            want_d;
        logic [PW-1:0] pte;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            i_va = {$urandom, $urandom}; d_va = {$urandom, $urandom};
            i_req = 1'b1; d_req = 1'b1;
            for (int g = 0; g < 2; g++) begin
                want_d = (g == 1);
                step();
                wait_walk_req(ok);
                total++;
                if (!ok || walk_va !== (want_d ? d_va : i_va)) begin
                    bad++; $display("FAIL tie_grant r%0d g%0d: got ok=%b va=%h want %h",
                                    r, g, ok, walk_va, want_d ? d_va : i_va);
                end
                pte = {$urandom, $urandom};
                twu_respond(3, pte, 1'b0);
                total++;
                if ({i_ack, d_ack} !== (want_d ? 2'b01 : 2'b10)) begin
                    bad++; $display("FAIL tie_ack r%0d g%0d: got %b%b want %b",
                                    r, g, i_ack, d_ack, want_d ? 2'b01 : 2'b10);
                end
                if (want_d) begin
                    d_req = 1'b0; exp_d_pte = pte;
                end else begin
                    i_req = 1'b0; exp_i_pte = pte;
                end
                exp_i_fault = 1'b0; exp_d_fault = 1'b0;
                last_m = want_d;
            end
            step();
        end
    endtask

    task automatic test_fault_d();
        bit ok;
        d_va  = {$urandom, $urandom};
        d_req = 1'b1;
        wait_walk_req(ok);
        total++;
        if (!ok || walk_va !== d_va) begin
            bad++; $display("FAIL fault_grant: got ok=%b va=%h want %h", ok, walk_va, d_va);
        end
        twu_respond(2, '0, 1'b1);
        total++;
        if (d_ack !== 1'b1 || d_fault !== 1'b1 || d_pte !== '0 || i_ack !== 1'b0) begin
            bad++; $display("FAIL fault_ack: got ack=%b flt=%b pte=%h iack=%b want 1 1 0 0",
                            d_ack, d_fault, d_pte, i_ack);
        end
        exp_d_pte = '0; exp_d_fault = 1'b1; last_m = 1'b1;
        d_req = 1'b0;
        step();
        total++;
        if (busy !== 1'b0 || d_ack !== 1'b0) begin
            bad++; $display("FAIL fault_after: got busy=%b ack=%b want 0 0", busy, d_ack);
        end
    endtask

    task automatic test_flush_mid();
        bit            ok;
        logic [PW-1:0] pte;
        d_va  = {$urandom, $urandom};
        d_req = 1'b1;
        wait_walk_req(ok);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if (walk_req !== 1'b1 || walk_va !== d_va) begin
            bad++; $display("FAIL flush_hold: got req=%b va=%h want 1 %h", walk_req, walk_va, d_va);
        end
        twu_respond(3, 64'hdead_beef_0000_0001, 1'b0);
        total++;
        if (d_ack !== 1'b0 || busy !== 1'b0 || walk_req !== 1'b0 || d_pte !== exp_d_pte) begin
            bad++; $display("FAIL flush_drop: got ack=%b busy=%b req=%b pte=%h want 0 0 0 %h",
                            d_ack, busy, walk_req, d_pte, exp_d_pte);
        end
        d_req = 1'b0;
        i_va  = {$urandom, $urandom};
        i_req = 1'b1;
        wait_walk_req(ok);
        total++;
        if (!ok || walk_va !== i_va || d_ack !== 1'b0) begin
            bad++; $display("FAIL flush_next_grant: got ok=%b va=%h dack=%b want %h", ok, walk_va,
                            d_ack, i_va);
        end
        pte = {$urandom, $urandom};
        twu_respond(2, pte, 1'b0);
        total++;
        if (i_ack !== 1'b1 || i_pte !== pte) begin
            bad++; $display("FAIL flush_next_ack: got %b %h want 1 %h", i_ack, i_pte, pte);
        end
        exp_i_pte = pte; exp_i_fault = 1'b0; last_m = 1'b0;
        i_req = 1'b0;
        step();
    endtask

    task automatic test_flush_same();
        bit            ok;
        logic [PW-1:0] pte;
        i_va  = {$urandom, $urandom};
        i_req = 1'b1;
        wait_walk_req(ok);
        step();
        flush = 1'b1; walk_done = 1'b1; walk_pte = 64'h1111_2222_3333_4444;
        step();
        flush = 1'b0; walk_done = 1'b0;
        i_req = 1'b0;
        total++;
        if (i_ack !== 1'b0 || busy !== 1'b0 || walk_req !== 1'b0 || i_pte !== exp_i_pte) begin
            bad++; $display("FAIL same_drop: got ack=%b busy=%b req=%b pte=%h want 0 0 0 %h",
                            i_ack, busy, walk_req, i_pte, exp_i_pte);
        end
        // The next walk must complete normally.
        d_va  = {$urandom, $urandom};
        d_req = 1'b1;
        wait_walk_req(ok);
        pte = {$urandom, $urandom};
        twu_respond(1, pte, 1'b0);
        total++;
        if (d_ack !== 1'b1 || d_pte !== pte || i_ack !== 1'b0) begin
            bad++; $display("FAIL same_next: got dack=%b pte=%h iack=%b want 1 %h 0",
                            d_ack, d_pte, i_ack, pte);
        end
        exp_d_pte = pte; exp_d_fault = 1'b0; last_m = 1'b1;
        d_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        i_va  = {$urandom, $urandom};
        i_req = 1'b1;
        wait_walk_req(ok);
        step();
        rstn = 1'b0;
        #1;
        total++;
        if ({walk_req, i_ack, d_ack, i_fault, d_fault, busy} !== 6'b0 || walk_va !== '0 ||
            i_pte !== '0 || d_pte !== '0) begin
            bad++; $display("FAIL reset_mid: got flags=%b va=%h ipte=%h dpte=%h want all 0",
                            {walk_req, i_ack, d_ack, i_fault, d_fault, busy}, walk_va, i_pte,
                            d_pte);
        end
        i_req = 1'b0;
        #2;
        rstn = 1'b1;
        last_m = 1'b1;
        exp_i_pte = '0; exp_d_pte = '0; exp_i_fault = 1'b0; exp_d_fault = 1'b0;
        step();
        walk_done = 1'b1;
        step();
        walk_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (i_ack !== 1'b0 || d_ack !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL stray_done c%0d: got i=%b d=%b busy=%b want 0 0 0",
                                k, i_ack, d_ack, busy);
            end
            step();
        end
    endtask

    task automatic test_random();
        bit            ok, own_d;
        int            lat, mode, fa;
        logic [PW-1:0] pte;
        bit            flt;
        for (int r = 0; r < 60; r++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_va = {$urandom, $urandom}; i_req = 1'b1;
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_va = {$urandom, $urandom}; d_req = 1'b1;
            end
            if (!i_req && !d_req) begin
                i_va = {$urandom, $urandom}; i_req = 1'b1;
            end
            // Round-robin: alone wins; on a tie, whoever was not served last.
            if (i_req && d_req) own_d = (last_m == 1'b0);
            else                own_d = d_req;
            wait_walk_req(ok);
            total++;
            if (!ok || walk_va !== (own_d ? d_va : i_va)) begin
                bad++; $display("FAIL rnd_grant r%0d: got ok=%b va=%h want %h", r, ok, walk_va,
                                own_d ? d_va : i_va);
            end
            lat  = $urandom_range(1, 6);
            mode = $urandom_range(0, 5);
            pte  = {$urandom, $urandom};
            flt  = 1'($urandom_range(0, 1));
            if (mode == 0 && lat >= 2) begin
                fa = $urandom_range(0, lat - 2);
                for (int k = 0; k < lat; k++) begin
                    if (k == fa) flush = 1'b1;
                    if (k == lat - 1) begin
                        walk_done = 1'b1; walk_pte = pte; walk_fault = flt;
                    end
                    step();
                    flush = 1'b0;
                end
                walk_done = 1'b0;
            end else if (mode <= 1) begin
                repeat (lat - 1) step();
                flush = 1'b1; walk_done = 1'b1; walk_pte = pte; walk_fault = flt;
                step();
                flush = 1'b0; walk_done = 1'b0;
            end else begin
                twu_respond(lat, pte, flt);
                if (own_d) begin
                    exp_d_pte = pte; exp_d_fault = flt;
                end else begin
                    exp_i_pte = pte; exp_i_fault = flt;
                end
            end
            total++;
            if ({i_ack, d_ack} !== ((mode <= 1) ? 2'b00 : (own_d ? 2'b01 : 2'b10)) ||
                i_pte !== exp_i_pte || d_pte !== exp_d_pte ||
                i_fault !== exp_i_fault || d_fault !== exp_d_fault) begin
                bad++; $display("FAIL rnd_result r%0d m%0d: got ack=%b%b i=%h/%b d=%h/%b want ack=%b i=%h/%b d=%h/%b",
                                r, mode, i_ack, d_ack, i_pte, i_fault, d_pte, d_fault,
                                (mode <= 1) ? 2'b00 : (own_d ? 2'b01 : 2'b10),
                                exp_i_pte, exp_i_fault, exp_d_pte, exp_d_fault);
            end
            if (mode > 1) begin
                if (own_d) d_req = 1'b0;
                else       i_req = 1'b0;
                last_m = own_d;
                step();
            end
            total++;
            if (busy !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
                bad++; $display("FAIL rnd_idle r%0d: got busy=%b ack=%b%b want 0 00",
                                r, busy, i_ack, d_ack);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_tie();
        test_fault_d();
        test_flush_mid();
        test_flush_same();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
